// File: rtl/text_console_writer_if.sv
// Byte-input / character-RAM-write bundle for text_console_writer.
// slave is the writer's side and master is the byte producer's side.
interface text_console_writer_if #(
  parameter int ADDR_W = 9
);
  logic [7:0]        i_data;
  logic              i_valid;
  logic              o_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data;
  logic [4:0]        o_top_row;
  logic [ADDR_W-1:0] o_cursor_addr;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_top_row, o_cursor_addr
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_top_row, o_cursor_addr
  );
endinterface

// File: rtl/text_console_writer.sv
// Byte-stream writer for the text screen character RAM: cursor, control codes, clears.
// TEXT_SCROLL_EN: when defined, the bottom row scrolls by rotating o_top_row; otherwise the cursor wraps to row 0.
module text_console_writer #(
  parameter int         COLS       = 25,
  parameter int         ROWS       = 18,
  parameter int         ADDR_W     = 9,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic                 i_pix_clk,
  input  logic                 i_reset,
  text_console_writer_if.slave bus
);
  localparam int CW    = $clog2(COLS);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] SCREEN_CELLS = CNT_W'(COLS * ROWS);
  localparam logic [CNT_W-1:0] LINE_CELLS   = CNT_W'(COLS);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {S_CLEAR_SCREEN, S_IDLE, S_CLEAR_LINE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] clr_base;
  logic [CW-1:0]     col;
  logic [4:0]        lr;
  logic [4:0]        top_row;
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] cursor;

  logic [CW-1:0]     nxt_col;
  logic [4:0]        nxt_lr;
  logic [4:0]        nxt_top;
  logic [4:0]        clr_row;
  logic [ADDR_W-1:0] nxt_cursor;
  logic              adv;
  logic              bottom;
  logic              accept;

  // Row sums never reach 2*ROWS, so one conditional subtract is a full mod.
  function automatic logic [4:0] wrap(input logic [5:0] s);
    return (s >= 6'(ROWS)) ? 5'(s - 6'(ROWS)) : s[4:0];
  endfunction

  function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] r);
    return ADDR_W'(r) * ADDR_W'(COLS);
  endfunction

  assign accept = (state == S_IDLE) && bus.i_valid;

  always_comb begin
    nxt_col = col;
    adv     = 1'b0;
    case (bus.i_data)
      CH_LF: begin
        nxt_col = '0;
        adv     = 1'b1;
      end
      CH_CR: nxt_col = '0;
      CH_BS: if (col != '0) nxt_col = col - CW'(1);
      CH_FF: nxt_col = '0;
      default: begin
        if (col == CW'(COLS - 1)) begin
          nxt_col = '0;
          adv     = 1'b1;
        end else begin
          nxt_col = col + CW'(1);
        end
      end
    endcase
    bottom  = adv && (lr == 5'(ROWS - 1));
    nxt_lr  = lr;
    nxt_top = top_row;
    clr_row = '0;
    if (adv && !bottom) begin
      nxt_lr = lr + 5'd1;
    end else if (bottom) begin
`ifdef TEXT_SCROLL_EN
      // The old top row becomes the new bottom row and must be blanked.
      nxt_top = wrap({1'b0, top_row} + 6'd1);
      clr_row = top_row;
`else
      nxt_lr  = '0;
`endif
    end
    nxt_cursor = row_base(wrap({1'b0, nxt_top} + {1'b0, nxt_lr})) + ADDR_W'(nxt_col);
  end

`ifdef TEXT_SCROLL_EN
  always_ff @(posedge i_pix_clk) begin
    if (i_reset)     top_row <= '0;
    else if (accept) top_row <= (bus.i_data == CH_FF) ? 5'd0 : nxt_top;
  end
`else
  assign top_row = '0;
`endif

  always_ff @(posedge i_pix_clk) begin
    if (i_reset) begin
      state    <= S_CLEAR_SCREEN;
      cnt      <= '0;
      clr_base <= '0;
      col      <= '0;
      lr       <= '0;
      ready    <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cursor   <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_CLEAR_SCREEN: begin
          if (cnt == SCREEN_CELLS) begin
            state  <= S_IDLE;
            ready  <= 1'b1;
            col    <= '0;
            lr     <= '0;
            cursor <= '0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= cnt[ADDR_W-1:0];
            wr_data <= BLANK_CHAR;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        S_CLEAR_LINE: begin
          if (cnt == LINE_CELLS) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= clr_base + cnt[ADDR_W-1:0];
            wr_data <= BLANK_CHAR;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (accept) begin
            col      <= nxt_col;
            lr       <= nxt_lr;
            cursor   <= nxt_cursor;
            clr_base <= row_base(clr_row);
            case (bus.i_data)
              CH_LF: begin
                // Cell 0 of the cleared row goes out with the accept itself.
                if (bottom) begin
                  wr_en   <= 1'b1;
                  wr_addr <= row_base(clr_row);
                  wr_data <= BLANK_CHAR;
                  cnt     <= CNT_W'(1);
                  state   <= S_CLEAR_LINE;
                  ready   <= 1'b0;
                end
              end
              CH_CR: begin
              end
              CH_BS: begin
                if (col != '0) begin
                  wr_en   <= 1'b1;
                  wr_addr <= nxt_cursor;
                  wr_data <= BLANK_CHAR;
                end
              end
              CH_FF: begin
                wr_en   <= 1'b1;
                wr_addr <= '0;
                wr_data <= BLANK_CHAR;
                cnt     <= CNT_W'(1);
                state   <= S_CLEAR_SCREEN;
                ready   <= 1'b0;
                col     <= '0;
                lr      <= '0;
                cursor  <= '0;
              end
              default: begin
                wr_en   <= 1'b1;
                wr_addr <= cursor;
                wr_data <= bus.i_data;
                if (bottom) begin
                  cnt   <= '0;
                  state <= S_CLEAR_LINE;
                  ready <= 1'b0;
                end
              end
            endcase
          end
        end
        default: state <= S_CLEAR_SCREEN;
      endcase
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_wr_en       = wr_en;
  assign bus.o_wr_addr     = wr_addr;
  assign bus.o_wr_data     = wr_data;
  assign bus.o_top_row     = top_row;
  assign bus.o_cursor_addr = cursor;
endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table plus hand-written clear/scroll/reset sequences.
module tb_text_console_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  text_console_writer_if #(.ADDR_W(9)) bus ();

  text_console_writer dut (
    .i_pix_clk(clk),
    .i_reset  (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

`ifdef TEXT_SCROLL_EN
  localparam int LF_TOP   = 1;
  localparam int WRAP_ROW = 0;
  localparam int WRAP_CLR = 25;
  localparam int WRAP_CUR = 25;
  localparam int WRAP_TOP = 2;
`else
  localparam int LF_TOP   = 0;
  localparam int WRAP_ROW = 425;
  localparam int WRAP_CLR = 0;
  localparam int WRAP_CUR = 0;
  localparam int WRAP_TOP = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       en;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [8:0] cur;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Samples each cycle until o_ready returns; blanks must land at base, base+1, ...
  task automatic measure(input string name, input int n, input int base, input int exp_low, input bit drop);
    int writes = 0;
    int low    = 0;
    bit done   = 1'b0;
    for (int c = 0; c < exp_low + 20 && !done; c++) begin
      @(posedge clk);
      #1;
      if (drop) bus.i_valid = 1'b0;
      if (bus.o_ready) begin
        done = 1'b1;
        chk({name, "_en_at_ready"}, 32'(bus.o_wr_en), 0);
      end else begin
        low++;
        if (bus.o_wr_en) begin
          chk({name, "_addr"}, 32'(bus.o_wr_addr), 32'(base + writes));
          chk({name, "_data"}, 32'(bus.o_wr_data), 32'h20);
          writes++;
        end
      end
    end
    chk({name, "_ready_returned"}, 32'(done), 1);
    chk({name, "_writes"}, 32'(writes), 32'(n));
    chk({name, "_ready_low"}, 32'(low), 32'(exp_low));
  endtask

  initial begin
    tbl[0] = '{8'h41, 1'b1, 9'd0, 8'h41, 9'd1};
    tbl[1] = '{8'h42, 1'b1, 9'd1, 8'h42, 9'd2};
    tbl[2] = '{8'h08, 1'b1, 9'd1, 8'h20, 9'd1};
    tbl[3] = '{8'h08, 1'b1, 9'd0, 8'h20, 9'd0};
    tbl[4] = '{8'h08, 1'b0, 9'd0, 8'h00, 9'd0};
    tbl[5] = '{8'h43, 1'b1, 9'd0, 8'h43, 9'd1};
    tbl[6] = '{8'h0D, 1'b0, 9'd0, 8'h00, 9'd0};

    bus.i_data  = 8'h00;
    bus.i_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.o_ready), 0);
    chk("rst_wr_en", 32'(bus.o_wr_en), 0);
    chk("rst_wr_addr", 32'(bus.o_wr_addr), 0);
    chk("rst_wr_data", 32'(bus.o_wr_data), 0);
    chk("rst_top", 32'(bus.o_top_row), 0);
    chk("rst_cursor", 32'(bus.o_cursor_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    measure("init_clr", 450, 0, 450, 1'b0);
    chk("init_cursor", 32'(bus.o_cursor_addr), 0);

    // Back-to-back table vectors, one byte per cycle
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(bus.o_ready), 1);
      bus.i_data  = tbl[i].data;
      bus.i_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i), 32'(bus.o_wr_en), 32'(tbl[i].en));
      if (tbl[i].en) begin
        chk($sformatf("v%0d_addr", i), 32'(bus.o_wr_addr), 32'(tbl[i].addr));
        chk($sformatf("v%0d_data", i), 32'(bus.o_wr_data), 32'(tbl[i].wdata));
      end
      chk($sformatf("v%0d_cursor", i), 32'(bus.o_cursor_addr), 32'(tbl[i].cur));
    end
    bus.i_valid = 1'b0;

    // Full row of printables wraps to row 1 col 0
    for (int i = 0; i < 25; i++) begin
      send(8'h41);
      chk("row_en", 32'(bus.o_wr_en), 1);
      chk("row_addr", 32'(bus.o_wr_addr), 32'(i));
    end
    chk("row_cursor", 32'(bus.o_cursor_addr), 25);
    chk("row_ready", 32'(bus.o_ready), 1);
    send(8'h0D);
    chk("cr_en", 32'(bus.o_wr_en), 0);
    chk("cr_cursor", 32'(bus.o_cursor_addr), 25);
    send(8'h0A);
    chk("lf_en", 32'(bus.o_wr_en), 0);
    chk("lf_cursor", 32'(bus.o_cursor_addr), 50);

    // FF with a printable held on i_valid the whole time
    @(negedge clk);
    bus.i_data  = 8'h0C;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("ff_first_en", 32'(bus.o_wr_en), 1);
    chk("ff_first_addr", 32'(bus.o_wr_addr), 0);
    chk("ff_ready", 32'(bus.o_ready), 0);
    chk("ff_cursor", 32'(bus.o_cursor_addr), 0);
    bus.i_data = 8'h58;
    measure("ff_clr", 449, 1, 449, 1'b0);
    chk("ff_top", 32'(bus.o_top_row), 0);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("held_en", 32'(bus.o_wr_en), 1);
    chk("held_addr", 32'(bus.o_wr_addr), 0);
    chk("held_data", 32'(bus.o_wr_data), 32'h58);
    chk("held_cursor", 32'(bus.o_cursor_addr), 1);
    @(posedge clk);
    #1;
    chk("held_once", 32'(bus.o_wr_en), 0);

    // LF into the bottom row
    send(8'h0D);
    for (int i = 0; i < 17; i++) send(8'h0A);
    chk("lf17_cursor", 32'(bus.o_cursor_addr), 425);
    chk("lf17_en", 32'(bus.o_wr_en), 0);
    @(negedge clk);
    bus.i_data  = 8'h0A;
    bus.i_valid = 1'b1;
    measure("lf_clr", 25, 0, 25, 1'b1);
    chk("lf_bot_top", 32'(bus.o_top_row), 32'(LF_TOP));
    chk("lf_bot_cursor", 32'(bus.o_cursor_addr), 0);

    // Printable wrapping at the bottom row
`ifndef TEXT_SCROLL_EN
    for (int i = 0; i < 17; i++) send(8'h0A);
`endif
    for (int i = 0; i < 24; i++) send(8'h5A);
    chk("wrap_pre_addr", 32'(bus.o_wr_addr), 32'(WRAP_ROW + 23));
    @(negedge clk);
    bus.i_data  = 8'h5A;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("wrap_en", 32'(bus.o_wr_en), 1);
    chk("wrap_addr", 32'(bus.o_wr_addr), 32'(WRAP_ROW + 24));
    chk("wrap_data", 32'(bus.o_wr_data), 32'h5A);
    chk("wrap_ready", 32'(bus.o_ready), 0);
    chk("wrap_top", 32'(bus.o_top_row), 32'(WRAP_TOP));
    chk("wrap_cursor", 32'(bus.o_cursor_addr), 32'(WRAP_CUR));
    measure("wrap_clr", 25, WRAP_CLR, 25, 1'b0);

    // Reset in the middle of a screen clear
    send(8'h0C);
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_en", 32'(bus.o_wr_en), 0);
    chk("midrst_ready", 32'(bus.o_ready), 0);
    chk("midrst_top", 32'(bus.o_top_row), 0);
    @(posedge clk);
    #1;
    chk("midrst_en2", 32'(bus.o_wr_en), 0);
    @(negedge clk);
    rst = 1'b0;
    measure("rerst_clr", 450, 0, 450, 1'b0);
    chk("rerst_cursor", 32'(bus.o_cursor_addr), 0);
    send(8'h51);
    chk("post_addr", 32'(bus.o_wr_addr), 0);
    chk("post_data", 32'(bus.o_wr_data), 32'h51);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/text_console_writer.md
# text_console_writer

Byte-stream writer for the text screen's character RAM. Accepts ASCII bytes over a valid/ready handshake, tracks a cursor, interprets a small set of control codes, and issues single-cycle writes into the character RAM that the tile layer reads. Scrolling is implemented by rotating a top-row index that the tile layer uses as its vertical row offset.

## Interface
- COLS, 25, characters per row (200-pixel line / 8-pixel glyph)
- ROWS, 18, character rows (150-pixel frame / 8-pixel glyph, truncated)
- ADDR_W, 9, character RAM address width; must satisfy 2^ADDR_W ≥ COLS*ROWS
- BLANK_CHAR, 8'h20, byte written when clearing cells

- i_pix_clk  input  1  clock; all logic is on the rising edge
- i_reset  input  1  reset; synchronous and active-high
- i_data  input  8  byte to write or control code
- i_valid  input  1  i_data is valid
- o_ready  output  1  writer can accept a byte this cycle
- o_wr_en  output  1  character RAM write strobe, one cycle per cell
- o_wr_addr  output  ADDR_W  physical cell address = phys_row*COLS + col
- o_wr_data  output  8  byte to store
- o_top_row  output  5  physical row shown at the top of the screen
- o_cursor_addr  output  ADDR_W  physical address of the current cursor cell

## Operation
- Transfer occurs on an edge where i_valid && o_ready. i_data is ignored otherwise. A byte held with o_ready low is not consumed.
- Cursor state: col (0..COLS-1), logical row lr (0..ROWS-1). phys_row = (o_top_row + lr) mod ROWS.
- States: S_CLEAR_SCREEN, S_IDLE, S_CLEAR_LINE. o_ready = 1 only in S_IDLE.
- In S_CLEAR_SCREEN, BLANK_CHAR is written to addresses 0..COLS*ROWS-1 in ascending order, one per cycle. On completion: col=0, lr=0, o_top_row=0, go to S_IDLE.
- In S_CLEAR_LINE, BLANK_CHAR is written to the COLS cells of the target physical row, col 0..COLS-1 ascending. Then go to S_IDLE.
- Byte handling in S_IDLE:
  - 8'h0A (LF): col=0, then row advance.
  - 8'h0D (CR): col=0. No write.
  - 8'h08 (BS): if col>0, col-=1 and BLANK_CHAR is written at the new position. If col==0, no effect.
  - 8'h0C (FF): enter S_CLEAR_SCREEN.
  - Any other byte: written at the cursor. Then col+=1. If col was COLS-1: col=0, then row advance.
- Row advance: if lr<ROWS-1, lr+=1 with no clear. If lr==ROWS-1, this is the bottom case, handled per Configuration.
- Address arithmetic: phys_row*COLS is a constant multiply. The mod-ROWS wrap is a compare-and-subtract, never a divide.

## Timing
- Reset: o_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_top_row=0, o_cursor_addr=0, col=lr=0, state=S_CLEAR_SCREEN.
- The first clear write appears in the first cycle after i_reset deasserts. o_ready rises COLS*ROWS (450) cycles later.
- Write outputs are registered. A byte accepted at edge N produces o_wr_en=1 during cycle N+1.
- Printable bytes sustain one byte per cycle with o_ready held high.
- A wrapping printable at the bottom, or an LF that triggers a clear: o_ready is low for cycles N+1..N+COLS, the clear writes occupy cycles N+1..N+COLS, and o_ready returns in cycle N+COLS+1. For a wrapping printable, its own write occurs in cycle N+1 and the clear writes follow in N+2..N+COLS+1, giving one extra cycle of o_ready low.
- o_top_row and o_cursor_addr update in the same cycle as the first write of the resulting action.
- Reset asserted mid-clear aborts the clear and restarts the S_CLEAR_SCREEN sequence from address 0.

## Configuration
- TEXT_SCROLL_EN defined: in the bottom case, o_top_row = (o_top_row+1) mod ROWS and lr stays ROWS-1. The row that becomes the new bottom (the old o_top_row) is cleared via S_CLEAR_LINE.
- TEXT_SCROLL_EN undefined: o_top_row is tied to 0. In the bottom case, lr wraps to 0 and physical row 0 is cleared via S_CLEAR_LINE.

## Test plan
- Release reset → exactly 450 writes of 8'h20 to addresses 0..449 ascending, then o_ready=1, o_cursor_addr=0.
- Send "AB" back-to-back → writes (0,8'h41), (1,8'h42) on consecutive cycles, o_cursor_addr=2. Then send BS → write (1,8'h20), o_cursor_addr=1.
- Send 25 × 8'h41 → last write at address 24, cursor at address 25 (row 1, col 0). Then CR → no write, cursor unchanged. Then LF → cursor at address 50.
- With TEXT_SCROLL_EN, send 17 LFs then 1 more LF → o_top_row=1, 25 clear writes at addresses 0..24, o_ready low for exactly 25 cycles, o_cursor_addr=0. Without the macro → o_top_row stays 0, same clear writes, o_cursor_addr=0.
- Send FF → 450 clear writes, o_top_row=0, cursor at address 0. Hold i_valid with 8'h58 throughout → no write of 8'h58 until o_ready returns, then exactly one write at address 0.
- Assert i_reset at cycle 100 of the clear → o_wr_en=0 during reset, then a full 450-write clear starting again from address 0.
